// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program counter and fetch controller for the 9-bit-instruction core.
//   Drives the combinational instruction ROM address, sequences a run from
//   start to halt, applies sequential / absolute / relative PC updates,
//   honours datapath stalls and counts the clocks spent running.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a program (sampled in IDLE and DONE)
//   prog_base    first instruction address, latched when a run begins
//   stall        freezes PC and FSM for the cycle (RUN only)
//   halt         current instruction ends the program
//   branch_en    current instruction is a taken branch
//   branch_rel   1 = relative (branch_off), 0 = absolute (branch_tgt)
//   branch_off   signed relative offset
//   branch_tgt   absolute branch target
//   prog_ctr     registered ROM address
//   fetch_valid  instruction at prog_ctr retires this cycle
//   busy         in RUN
//   done         in DONE
//   cycle_cnt    clocks spent in RUN for the current or last run
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | fetching; prog_ctr advances unless stalled
// DONE  | halt retired; prog_ctr / cycle_cnt held for readback
module fetch_sequencer #(
  parameter int D  = 12,
  parameter int OW = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  prog_base,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [OW-1:0] branch_off,
  input  logic [D-1:0]  branch_tgt,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [D-1:0]  r_prog_ctr;
  logic [CW-1:0] r_cycle_cnt;

  logic [D-1:0]  w_off_ext;
  logic          w_cnt_max;

  // Sign-extend the offset so an unsigned D-bit add gives modulo-2^D arithmetic.
  assign w_off_ext = {{(D-OW){branch_off[OW-1]}}, branch_off};
  assign w_cnt_max = (r_cycle_cnt == {CW{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prog_ctr  <= '0;
      r_cycle_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_prog_ctr  <= prog_base;
            r_cycle_cnt <= '0;
          end
        end
        S_RUN: begin
          // Stalled cycles still count as run time.
          if (!w_cnt_max) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
          end
          if (!stall) begin
            if (halt) begin
              // PC stays on the halt instruction for readback.
              r_state <= S_DONE;
            end else if (branch_en) begin
              if (branch_rel) begin
                r_prog_ctr <= r_prog_ctr + w_off_ext;
              end else begin
                r_prog_ctr <= branch_tgt;
              end
            end else begin
              r_prog_ctr <= r_prog_ctr + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign prog_ctr    = r_prog_ctr;
  assign cycle_cnt   = r_cycle_cnt;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign fetch_valid = (r_state == S_RUN) && !stall;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the 9-bit-instruction core; drives the instruction ROM address (`prog_ctr`).
- Sequences start/run/done and applies sequential, absolute-branch and relative-branch PC updates.
- Supports datapath stalls and keeps a cycle counter for performance reporting.
- Sits between the top-level start/done handshake and the ROM/decoder; the ROM is combinational, so the instruction at `prog_ctr` is decoded in the same cycle.

Parameters:
- D, 12: PC / ROM address width; PC arithmetic is modulo 2^D.
- OW, 6: width of the signed relative branch offset.
- CW, 16: width of the run-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a program; level sampled on clk.
- prog_base  in  D  address of the first instruction; latched when a run begins.
- stall  in  1  datapath stall; freezes PC and FSM for that cycle.
- halt  in  1  decoder flags the current instruction as the program end.
- branch_en  in  1  decoder flags the current instruction as a taken branch.
- branch_rel  in  1  1 = relative branch, 0 = absolute branch.
- branch_off  in  OW  signed two's-complement offset, used when branch_rel=1.
- branch_tgt  in  D  absolute target, used when branch_rel=0.
- prog_ctr  out  D  registered ROM address.
- fetch_valid  out  1  1 when `prog_ctr` holds an instruction that will retire this cycle.
- busy  out  1  1 in RUN.
- done  out  1  1 in DONE.
- cycle_cnt  out  CW  number of clocks spent in RUN in the current or last run.

Behaviour:
- Reset (synchronous, highest priority, also mid-run):
  - state=IDLE, prog_ctr=0, cycle_cnt=0, done=0, busy=0, fetch_valid=0.
- States: IDLE, RUN, DONE. Outputs are decoded from the registered state: busy=(RUN), done=(DONE), fetch_valid=(RUN & ~stall).
- IDLE:
  - start=1 -> RUN; prog_ctr<=prog_base; cycle_cnt<=0.
  - Otherwise hold all state.
- RUN, per cycle:
  - cycle_cnt increments by 1, including stalled cycles; saturates at 2^CW-1 (no wrap).
  - stall=1: prog_ctr holds and state holds; halt and branch_en are ignored that cycle.
  - stall=0, priority halt > branch_en > sequential:
    - halt=1 -> DONE next cycle; prog_ctr holds (it points at the halt instruction).
    - branch_en=1, branch_rel=1 -> prog_ctr <= prog_ctr + sign_extend(branch_off) mod 2^D.
    - branch_en=1, branch_rel=0 -> prog_ctr <= branch_tgt.
    - otherwise -> prog_ctr <= prog_ctr + 1 mod 2^D.
  - Address 2^D-1 wraps to 0 on sequential advance. There is no error flag.
  - start is ignored in RUN; re-asserting it does not restart the run.
- DONE:
  - done=1; prog_ctr and cycle_cnt hold their final values for readback.
  - start=1 -> RUN; prog_ctr<=prog_base; cycle_cnt<=0. This is a back-to-back restart with no IDLE visit.
  - start=0 -> stay in DONE.
- Timing and latency:
  - The first instruction is presented one clock after start is sampled.
  - done rises one clock after the halt instruction is presented without stall.
  - Instruction count = (#fetch_valid cycles).
- Simultaneous events:
  - reset beats everything.
  - stall beats halt and branch.
  - halt beats branch.
  - start beats nothing while in RUN.
- Inputs halt, branch_* and stall are only sampled in RUN.

Test Plan:
- Reset then start pulse with prog_base=0, no branches, halt asserted when prog_ctr=5 -> prog_ctr sequence 0,1,2,3,4,5 with fetch_valid=1; done=1 on the next clock with prog_ctr=5 held; cycle_cnt=6.
- Relative branches:
  - At prog_ctr=10: branch_en=1, branch_rel=1, branch_off=-3 (6'b111101) -> next prog_ctr=7.
  - At prog_ctr=4095: branch_off=+2 -> next prog_ctr=1 (wrap).
- Absolute branch and sequential wrap:
  - At prog_ctr=3: branch_en=1, branch_rel=0, branch_tgt=12'h800 -> next prog_ctr=12'h800.
  - Sequential from 12'hFFF -> 12'h000.
- Stall priority:
  - At prog_ctr=20: stall=1 for 3 cycles with halt=1 and branch_en=1 also asserted -> prog_ctr stays 20, fetch_valid=0, no DONE, cycle_cnt advances by 3.
  - Then stall=0 with halt=1 -> DONE.
- Halt/branch priority: halt=1 and branch_en=1 in the same unstalled cycle -> DONE, prog_ctr unchanged, branch not taken.
- Start and reset handshake:
  - Start in DONE with prog_base=100 -> RUN and prog_ctr=100 on the next clock, cycle_cnt reset to 0.
  - Start pulsed mid-RUN -> no effect.
  - reset asserted mid-RUN -> IDLE, prog_ctr=0, cycle_cnt=0, busy=0 on the next clock.
